// File: rtl/slv_pkt_arbiter.sv
// Three-channel packet arbiter: picks one eligible slave FIFO by priority with
// round-robin tie-break, requests the formatter, then streams one fixed-length packet.
module slv_pkt_arbiter #(
  parameter int DW  = 32,
  parameter int AVW = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           slv0_en_i,
  input  logic           slv1_en_i,
  input  logic           slv2_en_i,
  input  logic [1:0]     slv0_prio_i,
  input  logic [1:0]     slv1_prio_i,
  input  logic [1:0]     slv2_prio_i,
  input  logic [2:0]     slv0_len_i,
  input  logic [2:0]     slv1_len_i,
  input  logic [2:0]     slv2_len_i,
  input  logic [AVW-1:0] slv0_avail_i,
  input  logic [AVW-1:0] slv1_avail_i,
  input  logic [AVW-1:0] slv2_avail_i,
  input  logic [DW-1:0]  slv0_data_i,
  input  logic [DW-1:0]  slv1_data_i,
  input  logic [DW-1:0]  slv2_data_i,
  output logic [2:0]     slv_ack_o,
  output logic           fmt_req_o,
  input  logic           fmt_grant_i,
  output logic [1:0]     fmt_chid_o,
  output logic [5:0]     fmt_length_o,
  output logic           fmt_valid_o,
  output logic [DW-1:0]  fmt_data_o,
  output logic           fmt_last_o
);

  localparam int CW = (AVW > 6) ? AVW : 6;

  typedef enum logic [1:0] {IDLE, REQ, SEND} state_t;

  state_t         state, state_nxt;
  logic [2:0]     en_v;
  logic [1:0]     prio_v  [3];
  logic [2:0]     len_v   [3];
  logic [AVW-1:0] avail_v [3];
  logic [DW-1:0]  data_v  [3];
  logic [2:0]     elig;
  logic           pick_vld;
  logic [1:0]     pick_ch;
  logic [1:0]     pick_prio;
  logic [1:0]     last_gnt;
  logic [5:0]     beat;
  logic           beat_last;
  logic           vld_p0;
  logic           last_p0;
  logic [DW-1:0]  data_p0;

  // Codes 5..7 all map to the 32-word maximum.
  function automatic logic [5:0] len_words(input logic [2:0] code);
    return (code >= 3'd5) ? 6'd32 : (6'd1 << code);
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] base, input int step);
    int s;
    s = int'(base) + step;
    return (s >= 3) ? 2'(s - 3) : 2'(s);
  endfunction

  assign en_v       = {slv2_en_i, slv1_en_i, slv0_en_i};
  assign prio_v[0]  = slv0_prio_i;
  assign prio_v[1]  = slv1_prio_i;
  assign prio_v[2]  = slv2_prio_i;
  assign len_v[0]   = slv0_len_i;
  assign len_v[1]   = slv1_len_i;
  assign len_v[2]   = slv2_len_i;
  assign avail_v[0] = slv0_avail_i;
  assign avail_v[1] = slv1_avail_i;
  assign avail_v[2] = slv2_avail_i;
  assign data_v[0]  = slv0_data_i;
  assign data_v[1]  = slv1_data_i;
  assign data_v[2]  = slv2_data_i;

  always_comb begin
    for (int n = 0; n < 3; n++) begin
      elig[n] = en_v[n] && (CW'(avail_v[n]) >= CW'(len_words(len_v[n])));
    end
  end

  // Scan in round-robin order; strict less-than keeps the earliest channel on a tie.
  always_comb begin
    logic [1:0] cand;
    pick_vld  = 1'b0;
    pick_ch   = 2'd0;
    pick_prio = 2'd3;
    cand      = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      cand = rr_next(last_gnt, k);
      if (elig[cand] && (!pick_vld || (prio_v[cand] < pick_prio))) begin
        pick_vld  = 1'b1;
        pick_ch   = cand;
        pick_prio = prio_v[cand];
      end
    end
  end

  assign beat_last = (beat == (fmt_length_o - 6'd1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fmt_req_o = 1'b0;
    slv_ack_o = 3'b000;
    case (state)
      IDLE: if (pick_vld) state_nxt = REQ;
      REQ: begin
        fmt_req_o = 1'b1;
        if (fmt_grant_i) state_nxt = SEND;
      end
      SEND: begin
        slv_ack_o = 3'b001 << fmt_chid_o;
        if (beat_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_gnt     <= 2'd2;
      beat         <= 6'd0;
      fmt_chid_o   <= 2'd0;
      fmt_length_o <= 6'd0;
    end else begin
      if ((state == IDLE) && pick_vld) begin
        fmt_chid_o   <= pick_ch;
        fmt_length_o <= len_words(len_v[pick_ch]);
      end
      if ((state == REQ) && fmt_grant_i) last_gnt <= fmt_chid_o;
      if (state == SEND) beat <= beat_last ? 6'd0 : beat + 6'd1;
      else               beat <= 6'd0;
    end
  end

  // p0: one-cycle registered copy of the popped word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0  <= |slv_ack_o;
      last_p0 <= (state == SEND) && beat_last;
      if (|slv_ack_o) data_p0 <= data_v[fmt_chid_o];
    end
  end

  assign fmt_valid_o = vld_p0;
  assign fmt_last_o  = last_p0;
  assign fmt_data_o  = data_p0;

endmodule

// File: tb/tb_slv_pkt_arbiter.sv
// Randomized bench for slv_pkt_arbiter against a transaction-level arbitration model.
module tb_slv_pkt_arbiter;
  localparam int DW  = 32;
  localparam int AVW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           en_r    [3];
  logic [1:0]     prio_r  [3];
  logic [2:0]     len_r   [3];
  logic [AVW-1:0] avail_r [3];
  logic [DW-1:0]  base_r  [3];
  int unsigned    pop     [3] = '{0, 0, 0};
  logic [DW-1:0]  data_w  [3];
  logic           fmt_grant;
  logic [2:0]     slv_ack_o;
  logic           fmt_req_o;
  logic [1:0]     fmt_chid_o;
  logic [5:0]     fmt_length_o;
  logic           fmt_valid_o;
  logic [DW-1:0]  fmt_data_o;
  logic           fmt_last_o;

  int total = 0;
  int bad   = 0;
  int m_last = 2;
  int got;

  always #5 clk = ~clk;

  // FIFO heads advance on every pop.
  always @(posedge clk) begin
    for (int n = 0; n < 3; n++) if (slv_ack_o[n]) pop[n] <= pop[n] + 1;
  end
  assign data_w[0] = base_r[0] + DW'(pop[0]);
  assign data_w[1] = base_r[1] + DW'(pop[1]);
  assign data_w[2] = base_r[2] + DW'(pop[2]);

  slv_pkt_arbiter #(.DW(DW), .AVW(AVW)) dut (
    .clk_i(clk), .rst_i(rst),
    .slv0_en_i(en_r[0]), .slv1_en_i(en_r[1]), .slv2_en_i(en_r[2]),
    .slv0_prio_i(prio_r[0]), .slv1_prio_i(prio_r[1]), .slv2_prio_i(prio_r[2]),
    .slv0_len_i(len_r[0]), .slv1_len_i(len_r[1]), .slv2_len_i(len_r[2]),
    .slv0_avail_i(avail_r[0]), .slv1_avail_i(avail_r[1]), .slv2_avail_i(avail_r[2]),
    .slv0_data_i(data_w[0]), .slv1_data_i(data_w[1]), .slv2_data_i(data_w[2]),
    .slv_ack_o(slv_ack_o), .fmt_req_o(fmt_req_o), .fmt_grant_i(fmt_grant),
    .fmt_chid_o(fmt_chid_o), .fmt_length_o(fmt_length_o), .fmt_valid_o(fmt_valid_o),
    .fmt_data_o(fmt_data_o), .fmt_last_o(fmt_last_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int words(input int code);
    return (code >= 6) ? 32 : (1 << code);
  endfunction

  function automatic bit elig(input int n);
    return en_r[n] && (int'(avail_r[n]) >= words(int'(len_r[n])));
  endfunction

  // Lowest priority value wins; among equals, first channel after the last grant.
  function automatic int predict();
    int best = 4;
    for (int n = 0; n < 3; n++)
      if (elig(n) && int'(prio_r[n]) < best) best = int'(prio_r[n]);
    if (best == 4) return -1;
    for (int k = 1; k <= 3; k++)
      if (elig((m_last + k) % 3) && int'(prio_r[(m_last + k) % 3]) == best) return (m_last + k) % 3;
    return -1;
  endfunction

  task automatic clear_en();
    for (int n = 0; n < 3; n++) en_r[n] = 1'b0;
  endtask

  task automatic set_cfg(input logic [2:0] en, input logic [1:0] p0, p1, p2,
                         input logic [2:0] l0, l1, l2, input int a0, a1, a2);
    en_r[0] = en[0]; en_r[1] = en[1]; en_r[2] = en[2];
    prio_r[0] = p0; prio_r[1] = p1; prio_r[2] = p2;
    len_r[0] = l0; len_r[1] = l1; len_r[2] = l2;
    avail_r[0] = AVW'(a0); avail_r[1] = AVW'(a1); avail_r[2] = AVW'(a2);
  endtask

  // Called at a negedge with the DUT idle and no channel enabled; returns the
  // channel id the DUT requested, or -1 when it raised no request.
  task automatic run_pkt(input logic [2:0] en, input logic [1:0] p0, p1, p2,
                         input logic [2:0] l0, l1, l2, input int a0, a1, a2,
                         input int gdly, input bit mutate, output int obs_ch);
    int ec, len_w, st;
    set_cfg(en, p0, p1, p2, l0, l1, l2, a0, a1, a2);
    ec = predict();
    @(negedge clk);
    obs_ch = fmt_req_o ? int'(fmt_chid_o) : -1;
    if (ec < 0) begin
      repeat (3) begin
        chk("idle_req", {31'd0, fmt_req_o}, 0);
        chk("idle_ack", {29'd0, slv_ack_o}, 0);
        @(negedge clk);
      end
      clear_en();
      return;
    end
    len_w = words(int'(len_r[ec]));
    chk("req", {31'd0, fmt_req_o}, 1);
    chk("chid", {30'd0, fmt_chid_o}, ec);
    chk("length", {26'd0, fmt_length_o}, len_w);
    if (fmt_req_o !== 1'b1) begin
      clear_en();
      return;
    end
    for (int d = 0; d < gdly; d++) begin
      @(negedge clk);
      chk("req_hold", {31'd0, fmt_req_o}, 1);
      chk("chid_hold", {30'd0, fmt_chid_o}, ec);
    end
    fmt_grant = 1'b1;
    @(negedge clk);
    fmt_grant = 1'b0;
    m_last = ec;
    st = int'(pop[ec]);
    for (int i = 0; i < len_w; i++) begin
      chk("ack", {29'd0, slv_ack_o}, 32'(1 << ec));
      chk("req_off", {31'd0, fmt_req_o}, 0);
      if (i > 0) begin
        chk("valid", {31'd0, fmt_valid_o}, 1);
        chk("data", fmt_data_o, base_r[ec] + DW'(st + i - 1));
        chk("last_lo", {31'd0, fmt_last_o}, 0);
      end
      if (i == len_w - 1) clear_en();
      else if (mutate && i == len_w / 2) begin
        en_r[ec] = 1'b0; prio_r[ec] = 2'd3; len_r[ec] = 3'($urandom); avail_r[ec] = '0;
      end
      @(negedge clk);
    end
    chk("ack_end", {29'd0, slv_ack_o}, 0);
    chk("valid_end", {31'd0, fmt_valid_o}, 1);
    chk("data_end", fmt_data_o, base_r[ec] + DW'(st + len_w - 1));
    chk("last", {31'd0, fmt_last_o}, 1);
    @(negedge clk);
    chk("valid_off", {31'd0, fmt_valid_o}, 0);
    chk("last_off", {31'd0, fmt_last_o}, 0);
    chk("req_idle", {31'd0, fmt_req_o}, 0);
    chk("chid_held", {30'd0, fmt_chid_o}, ec);
    chk("len_held", {26'd0, fmt_length_o}, len_w);
    fmt_grant = 1'b1;
    @(negedge clk);
    chk("stray_grant_req", {31'd0, fmt_req_o}, 0);
    chk("stray_grant_ack", {29'd0, slv_ack_o}, 0);
    fmt_grant = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fmt_grant = 1'b0;
    base_r[0] = 32'h0000_00A0; base_r[1] = 32'h1100_0000; base_r[2] = 32'h2200_0000;
    set_cfg(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_ack", {29'd0, slv_ack_o}, 0);
    chk("rst_req", {31'd0, fmt_req_o}, 0);
    chk("rst_chid", {30'd0, fmt_chid_o}, 0);
    chk("rst_len", {26'd0, fmt_length_o}, 0);
    chk("rst_valid", {31'd0, fmt_valid_o}, 0);
    chk("rst_data", fmt_data_o, 0);
    chk("rst_last", {31'd0, fmt_last_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Round-robin among equal priorities starting from ch0.
    for (int r = 0; r < 6; r++) begin
      run_pkt(3'b111, 3, 3, 3, 0, 0, 0, 8, 8, 8, 0, 0, got);
      chk("rr_order", got, r % 3);
    end

    // ch0 alone, 4 words, grant on second request cycle.
    pop[0] = 0;
    run_pkt(3'b001, 0, 0, 0, 2, 0, 0, 4, 0, 0, 1, 0, got);
    chk("ch0_only", got, 0);

    // Priority beats round-robin, then ch0/ch1 share.
    run_pkt(3'b111, 1, 1, 0, 0, 0, 0, 8, 8, 8, 0, 0, got);
    chk("prio_ch2", got, 2);
    run_pkt(3'b011, 1, 1, 0, 0, 0, 0, 8, 8, 8, 0, 0, got);
    chk("prio_ch0", got, 0);
    run_pkt(3'b011, 1, 1, 0, 0, 0, 0, 8, 8, 8, 0, 0, got);
    chk("prio_ch1", got, 1);

    // Eligibility boundary on avail.
    run_pkt(3'b010, 3, 3, 3, 0, 3, 0, 0, 7, 0, 0, 0, got);
    chk("avail_short", got, -1);
    run_pkt(3'b010, 3, 3, 3, 0, 3, 0, 0, 8, 0, 0, 0, got);
    chk("avail_exact", got, 1);

    // Disable and reprioritise mid-packet; length code 7 saturates to 32.
    run_pkt(3'b001, 0, 0, 0, 3, 0, 0, 8, 0, 0, 2, 1, got);
    run_pkt(3'b001, 0, 0, 0, 7, 0, 0, 40, 0, 0, 0, 1, got);

    for (int t = 0; t < 40; t++) begin
      logic [2:0] en3, l0, l1, l2;
      int a[3];
      en3 = 3'($urandom);
      l0 = 3'($urandom); l1 = 3'($urandom); l2 = 3'($urandom);
      a[0] = words(int'(l0)) + int'($urandom_range(0, 2)) - 1;
      a[1] = words(int'(l1)) + int'($urandom_range(0, 2)) - 1;
      a[2] = words(int'(l2)) + int'($urandom_range(0, 2)) - 1;
      run_pkt(en3, 2'($urandom), 2'($urandom), 2'($urandom), l0, l1, l2,
              a[0], a[1], a[2], int'($urandom_range(0, 3)), 1'($urandom), got);
    end

    // Reset on beat 3 of an 8-word packet.
    set_cfg(3'b001, 3, 3, 3, 3, 0, 0, 8, 0, 0);
    @(negedge clk);
    chk("rs_req", {31'd0, fmt_req_o}, 1);
    fmt_grant = 1'b1;
    @(negedge clk);
    fmt_grant = 1'b0;
    repeat (3) @(negedge clk);
    chk("rs_beat3_ack", {29'd0, slv_ack_o}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rs_ack", {29'd0, slv_ack_o}, 0);
    chk("rs_valid", {31'd0, fmt_valid_o}, 0);
    chk("rs_req_off", {31'd0, fmt_req_o}, 0);
    rst = 1'b0;
    clear_en();
    m_last = 2;
    @(negedge clk);
    chk("rs_idle_ack", {29'd0, slv_ack_o}, 0);
    chk("rs_idle_req", {31'd0, fmt_req_o}, 0);
    run_pkt(3'b111, 3, 3, 3, 0, 0, 0, 8, 8, 8, 0, 0, got);
    chk("rs_rr_ch0", got, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/slv_pkt_arbiter.md
Name: slv_pkt_arbiter

Overview:
- Three-channel packet arbiter between the slave channel FIFOs and the packet formatter.
- Consumes the per-slave configuration from the control register block: enable, priority and packet-length code.
- Selects one eligible slave, requests the formatter, then streams one fixed-length packet from that slave's FIFO.
- Returns the chosen slave's words to the formatter with a one-cycle registered datapath.

Parameters:
- DW, 32, data word width.
- AVW, 8, width of per-slave FIFO available-word count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- slv0_en_i / slv1_en_i / slv2_en_i  in  1 each  channel enable from the register block.
- slv0_prio_i / slv1_prio_i / slv2_prio_i  in  2 each  priority; 0 is highest.
- slv0_len_i / slv1_len_i / slv2_len_i  in  3 each  length code; packet words = 2^code for codes 0..5, and 32 for codes 6 and 7.
- slv0_avail_i / slv1_avail_i / slv2_avail_i  in  AVW each  words currently held in each slave FIFO.
- slv0_data_i / slv1_data_i / slv2_data_i  in  DW each  FIFO head word (first-word-fall-through).
- slv_ack_o  out  3  one-hot FIFO pop, one bit per slave.
- fmt_req_o  out  1  packet request to the formatter.
- fmt_grant_i  in  1  formatter accepts the request.
- fmt_chid_o  out  2  granted channel id, 0..2.
- fmt_length_o  out  6  packet word count, 1..32.
- fmt_valid_o  out  1  fmt_data_o is valid this cycle.
- fmt_data_o  out  DW  packet word.
- fmt_last_o  out  1  final word of the packet.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, round-robin pointer last_gnt = 2 so ch0 wins the first tie.
- Eligibility: channel n is eligible when en_n = 1 and avail_n >= words(len_n).
- Arbitration (IDLE only):
  - Pick the eligible channel with the numerically lowest prio.
  - Break ties round-robin, starting from the channel after last_gnt (cyclic order 0, 1, 2).
  - prio, len and en are sampled only at this decision; later changes do not affect a packet in progress.
- FSM states:
  - IDLE: if any channel is eligible, latch chid and length, then go to REQ on the next cycle.
  - REQ: fmt_req_o = 1 with fmt_chid_o and fmt_length_o held stable. Stay until fmt_grant_i = 1, then update last_gnt and go to SEND. No timeout.
  - SEND: slv_ack_o[chid] = 1 for exactly `length` consecutive cycles, with a 6-bit beat counter counting up from 0. On the final ack cycle, go to IDLE.
- Datapath: fmt_data_o and fmt_valid_o are registered copies of the selected slvN_data_i and the ack pulse, one cycle after each ack. fmt_last_o is registered with the final word.
- Latency:
  - Eligible to fmt_req_o: 1 cycle.
  - fmt_grant_i to first ack: 1 cycle.
  - First ack to first fmt_valid_o: 1 cycle.
  - Minimum gap between packets: 1 IDLE cycle.
- Request output timing: fmt_req_o deasserts on the cycle after the grant. fmt_chid_o and fmt_length_o hold their values until the next REQ.
- Boundary conditions:
  - A channel disabled or reprioritised mid-packet: the packet completes unchanged.
  - avail exactly equal to the packet size: eligible.
  - fmt_grant_i while not in REQ: ignored.
  - No eligible channel: stay in IDLE with all outputs 0 except held chid and length.
  - rst_i mid-SEND: next cycle all acks and valids are 0 and the FSM is in IDLE. The partial packet is abandoned and is not resumed.
  - Length codes 6 and 7 saturate to 32 words; fmt_length_o = 6'd32.

Test Plan:
- ch0 only: en = 1, prio = 0, len = 2, avail = 4, data 0xA0..0xA3, grant on the 2nd REQ cycle -> fmt_chid_o = 0, fmt_length_o = 4, four acks, fmt_data_o = 0xA0..0xA3 with fmt_last_o on 0xA3.
- Priority: ch2 prio = 0, ch0/ch1 prio = 1, all eligible, len = 0 -> ch2 granted first, then ch0, then ch1.
- Round-robin tie: all prio = 3, len = 0, avail = 8, grant immediately -> grant order 0, 1, 2, 0, 1, 2.
- Eligibility boundary: ch1 len = 3, avail = 7 -> no request; avail = 8 -> fmt_req_o within 1 cycle, length = 8.
- Mid-packet changes: during ch0 SEND, set slv0_en_i = 0 and slv0_prio_i = 3 -> all 8 words still delivered.
- Reset in SEND: assert rst_i on beat 3 of 8 -> next cycle slv_ack_o = 0, fmt_valid_o = 0, FSM idle; after release, ch0 wins the tie again (last_gnt reset to 2).
